regfile_dump: RTL and testbench

REGFILE_DUMP -- requirements
Module: regfile_dump

---
 rtl/regfile_dump.sv | 135 +++++++++++++
 tb/tb_regfile_dump.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// Streams register file contents START_REG..END_REG over a valid/ready port,
// one word per three cycles. Optional build macro: REGDUMP_SKIP_ZERO_EN drops zero-valued words.
module regfile_dump #(
    parameter int START_REG = 0,
    parameter int END_REG   = 31
) (
    input  logic        clk,
    input  logic        res,
    input  logic        start,
    output logic [4:0]  radd_debug,
    input  logic [31:0] dout_debug,
    output logic [4:0]  tx_addr,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic [5:0]  tx_count
);

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, SEND, FIN} state_t;

    localparam logic [4:0] START_IDX = 5'(START_REG);
    localparam logic [4:0] END_IDX   = 5'(END_REG);

    // Handshake: a word moves on any posedge where tx_valid and tx_ready are both 1;
    // while tx_valid is 1 and tx_ready is 0, tx_addr/tx_data/tx_valid hold.
    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  radd_q, radd_d;
    logic [4:0]  tx_addr_q, tx_addr_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [5:0]  tx_count_q, tx_count_d;
    logic        word_done;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tx_addr_d  = tx_addr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tx_count_d = tx_count_q;
        word_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d      = START_IDX;
                    tx_count_d = 6'd0;
                    busy_d     = 1'b1;
                    state_d    = ADDR;
                end
            end
            ADDR: state_d = WAIT;
            WAIT: begin
`ifdef REGDUMP_SKIP_ZERO_EN
                if (dout_debug == 32'd0) begin
                    word_done = 1'b1;
                end else begin
                    tx_data_d  = dout_debug;
                    tx_addr_d  = idx_q;
                    tx_valid_d = 1'b1;
                    state_d    = SEND;
                end
`else
                tx_data_d  = dout_debug;
                tx_addr_d  = idx_q;
                tx_valid_d = 1'b1;
                state_d    = SEND;
`endif
            end
            SEND: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    tx_count_d = tx_count_q + 6'd1;
                    word_done  = 1'b1;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Shared advance for an accepted word and a skipped zero word.
        if (word_done) begin
            if (idx_q == END_IDX) begin
                state_d = FIN;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end else begin
                idx_d   = idx_q + 5'd1;
                state_d = ADDR;
            end
        end

        radd_d = (state_d == ADDR || state_d == WAIT || state_d == SEND) ? idx_d : radd_q;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= IDLE;
            idx_q      <= START_IDX;
            radd_q     <= 5'd0;
            tx_addr_q  <= 5'd0;
            tx_data_q  <= 32'd0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_count_q <= 6'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            radd_q     <= radd_d;
            tx_addr_q  <= tx_addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_count_q <= tx_count_d;
        end
    end

    assign radd_debug = radd_q;
    assign tx_addr    = tx_addr_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign tx_count   = tx_count_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: random ready/register stimulus against a queue-based model
// of the words a dump must deliver; a second instance covers a one-register range.
module tb_regfile_dump;

`ifdef REGDUMP_SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  radd_debug;
    logic [31:0] dout_debug = 32'd0;
    logic [4:0]  tx_addr;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic        done;
    logic [5:0]  tx_count;

    logic        start4 = 1'b0;
    logic [4:0]  radd4;
    logic [31:0] dout4 = 32'd0;
    logic [4:0]  tx_addr4;
    logic [31:0] tx_data4;
    logic        tx_valid4;
    logic        tx_ready4 = 1'b1;
    logic        busy4;
    logic        done4;
    logic [5:0]  tx_count4;

    logic [31:0] rf [32];
    logic [36:0] exp_q [$];
    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // Register file debug port: read on the falling edge.
    always @(negedge clk) begin
        dout_debug <= rf[radd_debug];
        dout4      <= rf[radd4];
    end

    regfile_dump u_dut (
        .clk(clk), .res(res), .start(start), .radd_debug(radd_debug), .dout_debug(dout_debug),
        .tx_addr(tx_addr), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done), .tx_count(tx_count)
    );

    regfile_dump #(.START_REG(4), .END_REG(4)) u_dut4 (
        .clk(clk), .res(res), .start(start4), .radd_debug(radd4), .dout_debug(dout4),
        .tx_addr(tx_addr4), .tx_data(tx_data4), .tx_valid(tx_valid4), .tx_ready(tx_ready4),
        .busy(busy4), .done(done4), .tx_count(tx_count4)
    );

    function automatic void build_exp(input int s, input int e);
        exp_q.delete();
        for (int i = s; i <= e; i++)
            if (!(SKIP_ZERO && rf[i] == 32'd0)) exp_q.push_back({5'(i), rf[i]});
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_dump(input int ready_pct, input int restart_at, input int stall_addr,
                            input int abort_addr, output int done_cyc, output int first_valid);
        int exp_n = exp_q.size();
        int accepted = 0;
        int stall_cnt = 0;
        bit held = 1'b0;
        bit restarted = 1'b0;
        logic [4:0]  h_addr = 5'd0;
        logic [31:0] h_data = 32'd0;
        logic [36:0] w;
        done_cyc = -1;
        first_valid = -1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (tx_valid && first_valid < 0) first_valid = cyc;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (abort_addr >= 0 && tx_valid && tx_addr == 5'(abort_addr)) begin
                tx_ready = 1'b0;
                res = 1'b1;
                @(negedge clk);
                res = 1'b0;
                tests_run++;
                if (busy !== 1'b0 || tx_valid !== 1'b0 || done !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL abort_state: busy=%b valid=%b done=%b, required 0 0 0", busy, tx_valid, done);
                end
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    tests_run++;
                    if (done !== 1'b0 || busy !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL abort_quiet: done=%b busy=%b, required 0 0", done, busy);
                    end
                end
                exp_q.delete();
                return;
            end
            tx_ready = ($urandom_range(99) < ready_pct);
            if (stall_addr >= 0 && tx_valid && tx_addr == 5'(stall_addr) && stall_cnt < 5) begin
                tx_ready = 1'b0;
                stall_cnt++;
            end
            if (restart_at >= 0 && accepted == restart_at && !restarted) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            if (tx_valid) begin
                tests_run++;
                if (radd_debug !== tx_addr) begin
                    tests_failed++;
                    $display("FAIL radd_in_send: radd=%0d, required %0d", radd_debug, tx_addr);
                end
                if (held) begin
                    tests_run++;
                    if (tx_addr !== h_addr || tx_data !== h_data) begin
                        tests_failed++;
                        $display("FAIL hold_stable: %0d/%h, required %0d/%h", tx_addr, tx_data, h_addr, h_data);
                    end
                end
                if (tx_ready) begin
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL extra_word: got %0d/%h, required none", tx_addr, tx_data);
                    end else begin
                        w = exp_q.pop_front();
                        if ({tx_addr, tx_data} !== w) begin
                            tests_failed++;
                            $display("FAIL word: got %0d/%h, required %0d/%h", tx_addr, tx_data, w[36:32], w[31:0]);
                        end
                    end
                    accepted++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    h_addr = tx_addr;
                    h_data = tx_data;
                end
            end
        end
        tests_run++;
        if (done_cyc < 0) begin
            tests_failed++;
            $display("FAIL timeout: no done within budget, required done");
            return;
        end
        if (exp_q.size() != 0 || tx_count !== 6'(exp_n) || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_state: missing=%0d tx_count=%0d busy=%b, required 0 %0d 0",
                     exp_q.size(), tx_count, busy, exp_n);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0 || tx_count !== 6'(exp_n)) begin
                tests_failed++;
                $display("FAIL post_done: done=%b busy=%b valid=%b cnt=%0d, required 0 0 0 %0d",
                         done, busy, tx_valid, tx_count, exp_n);
            end
        end
    endtask

    task automatic test_reset();
        res = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (radd_debug !== 5'd0 || tx_addr !== 5'd0 || tx_data !== 32'd0 || tx_valid !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || tx_count !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_values: radd=%0d addr=%0d data=%h v=%b busy=%b done=%b cnt=%0d, required all 0",
                     radd_debug, tx_addr, tx_data, tx_valid, busy, done, tx_count);
        end
        res = 1'b0;
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            tests_run++;
            if (busy !== 1'b0 || busy4 !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_wins: busy=%b busy4=%b, required 0 0", busy, busy4);
            end
        end
    endtask

    task automatic test_full_dump();
        int dc, fv;
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + 32'(i);
        build_exp(0, 31);
        pulse_start();
        run_dump(100, -1, -1, -1, dc, fv);
        tests_run++;
        if (fv != 2 || dc != 96) begin
            tests_failed++;
            $display("FAIL timing: first_valid=%0d done_cycle=%0d, required 2 96", fv, dc);
        end
    endtask

    task automatic test_stall();
        int dc, fv;
        for (int i = 0; i < 32; i++) rf[i] = $urandom | 32'h1;
        build_exp(0, 31);
        pulse_start();
        run_dump(100, -1, 3, -1, dc, fv);
    endtask

    task automatic test_restart_ignored();
        int dc, fv;
        build_exp(0, 31);
        pulse_start();
        run_dump(100, 10, -1, -1, dc, fv);
    endtask

    task automatic test_reset_mid();
        int dc, fv;
        build_exp(0, 31);
        pulse_start();
        run_dump(100, -1, -1, 7, dc, fv);
        build_exp(0, 31);
        pulse_start();
        run_dump(100, -1, -1, -1, dc, fv);
        tests_run++;
        if (fv != 2) begin
            tests_failed++;
            $display("FAIL fresh_start: first_valid=%0d, required 2", fv);
        end
    endtask

    task automatic test_random_ready();
        int dc, fv;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 32; i++) rf[i] = ($urandom_range(99) < 20) ? 32'd0 : $urandom;
            build_exp(0, 31);
            pulse_start();
            run_dump(30 + 20 * r, -1, -1, -1, dc, fv);
        end
    endtask

    task automatic test_zero_values();
        int dc, fv;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rf[5] = 32'hDEAD;
        rf[9] = 32'hBEEF;
        build_exp(0, 31);
        pulse_start();
        run_dump(100, -1, -1, -1, dc, fv);
        rf[5] = 32'd0;
        rf[9] = 32'd0;
        build_exp(0, 31);
        pulse_start();
        run_dump(70, -1, -1, -1, dc, fv);
    endtask

    task automatic test_single_reg();
        int valids = 0;
        bit seen_done = 1'b0;
        rf[4] = $urandom | 32'h1;
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        for (int cyc = 0; cyc < 30 && !seen_done; cyc++) begin
            @(negedge clk);
            if (done4) seen_done = 1'b1;
            if (tx_valid4) begin
                valids++;
                tests_run++;
                if (tx_addr4 !== 5'd4 || tx_data4 !== rf[4]) begin
                    tests_failed++;
                    $display("FAIL single_word: %0d/%h, required 4/%h", tx_addr4, tx_data4, rf[4]);
                end
            end
        end
        tests_run++;
        if (!seen_done || valids != 1 || tx_count4 !== 6'd1) begin
            tests_failed++;
            $display("FAIL single_done: done=%b valids=%0d cnt=%0d, required 1 1 1", seen_done, valids, tx_count4);
        end
    endtask

    task automatic test_back_to_back();
        int dc, fv;
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            build_exp(0, 31);
            pulse_start();
            run_dump(80, -1, -1, -1, dc, fv);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        test_reset();
        test_full_dump();
        test_stall();
        test_restart_ignored();
        test_reset_mid();
        test_random_ready();
        test_zero_values();
        test_single_reg();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
